// File: rtl/dispatch_allocator_pkg.sv
// dispatch_allocator_pkg: shared dispatch slot/result types and default sizing.
package dispatch_allocator_pkg;
  localparam int DEF_DISPATCH_WIDTH = 2;
  localparam int DEF_ROB_DEPTH = 16;
  localparam int DEF_LSQ_DEPTH = 8;
  localparam int DEF_RS_DEPTH = 8;
  localparam int DEF_COLOR_W = 4;
  localparam int TAG_W = $clog2(DEF_ROB_DEPTH + 1);
  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  typedef struct packed {
    logic valid;
    logic uses_rs;
    logic uses_lsq;
    logic is_store;
  } dispatch_slot_t;
  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic [$clog2(DEF_LSQ_DEPTH)-1:0] lsq_idx;
    logic [$clog2(DEF_RS_DEPTH)-1:0] rs_idx;
    logic rs_valid;
    logic [DEF_COLOR_W-1:0] color;
  } alloc_result_t;
endpackage

// File: rtl/dispatch_allocator_rs_free_picker.sv
// rs_free_picker: lowest PICK free indices and free count of a busy vector.
module rs_free_picker #(
  parameter int RS_DEPTH = 8,
  parameter int PICK = 2,
  localparam int SW = $clog2(RS_DEPTH),
  localparam int FW = $clog2(RS_DEPTH + 1)
) (
  input  logic [RS_DEPTH-1:0]      busy_i,
  output logic [PICK-1:0][SW-1:0]  idx_o,
  output logic [FW-1:0]            free_cnt_o
);
  always_comb begin
    idx_o = '0;
    free_cnt_o = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (!busy_i[i]) begin
        for (int k = 0; k < PICK; k++)
          if (free_cnt_o == FW'(k)) idx_o[k] = SW'(i);
        free_cnt_o = free_cnt_o + 1'b1;
      end
  end
endmodule

// File: rtl/dispatch_allocator.sv
// dispatch_allocator: all-or-nothing ROB/LSQ/RS/colour allocation for a dispatch group.
module dispatch_allocator
  import dispatch_allocator_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int LSQ_DEPTH = DEF_LSQ_DEPTH,
  parameter int RS_DEPTH = DEF_RS_DEPTH,
  parameter int NUM_RS_FREE = 2,
  parameter int COLOR_W = DEF_COLOR_W,
  localparam int RIW = $clog2(ROB_DEPTH),
  localparam int TW = $clog2(ROB_DEPTH + 1),
  localparam int LIW = $clog2(LSQ_DEPTH),
  localparam int LCW = $clog2(LSQ_DEPTH + 1),
  localparam int SW = $clog2(RS_DEPTH),
  localparam int CW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DISPATCH_WIDTH-1:0]     in_valid,
  input  logic [DISPATCH_WIDTH-1:0]     in_uses_rs,
  input  logic [DISPATCH_WIDTH-1:0]     in_uses_lsq,
  input  logic [DISPATCH_WIDTH-1:0]     in_is_store,
  output logic                          in_ready,
  input  logic [CW-1:0]                 rob_retire_cnt,
  input  logic [CW-1:0]                 lsq_retire_cnt,
  input  logic [NUM_RS_FREE-1:0]        rs_free_valid,
  input  logic [NUM_RS_FREE*SW-1:0]     rs_free_idx,
  input  logic                          flush,
  input  logic [RIW-1:0]                rob_head,
  input  logic [LIW-1:0]                lsq_head,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DISPATCH_WIDTH-1:0]     out_slot_valid,
  output logic [DISPATCH_WIDTH*TW-1:0]  out_rob_tag,
  output logic [DISPATCH_WIDTH*LIW-1:0] out_lsq_idx,
  output logic [DISPATCH_WIDTH*SW-1:0]  out_rs_idx,
  output logic [DISPATCH_WIDTH-1:0]     out_rs_valid,
  output logic [DISPATCH_WIDTH*COLOR_W-1:0] out_color,
  output logic [TW-1:0]                 rob_count,
  output logic [LCW-1:0]                lsq_count,
  output logic                          rob_full,
  output logic                          lsq_full
);
  logic [RIW-1:0] rob_tail_q, rob_tail_d;
  logic [LIW-1:0] lsq_tail_q, lsq_tail_d;
  logic [TW-1:0] rob_count_q, rob_count_d;
  logic [LCW-1:0] lsq_count_q, lsq_count_d;
  logic [RS_DEPTH-1:0] busy_q, busy_d, set_mask;
  logic [COLOR_W-1:0] color_q, color_d;
  logic out_valid_q, out_valid_d;
  logic [DISPATCH_WIDTH-1:0] slotv_q, rsv_q, rsv_d;
  logic [DISPATCH_WIDTH*TW-1:0] tag_q, tag_d;
  logic [DISPATCH_WIDTH*LIW-1:0] lidx_q, lidx_d;
  logic [DISPATCH_WIDTH*SW-1:0] ridx_q, ridx_d;
  logic [DISPATCH_WIDTH*COLOR_W-1:0] col_q, col_d;
  logic [DISPATCH_WIDTH-1:0][SW-1:0] pick;
  logic [$clog2(RS_DEPTH+1)-1:0] free_cnt;
  dispatch_slot_t [DISPATCH_WIDTH-1:0] slot;
  int nr, nl, ns;
  logic fit, accept;

  rs_free_picker #(.RS_DEPTH(RS_DEPTH), .PICK(DISPATCH_WIDTH)) u_pick (
    .busy_i(busy_q),
    .idx_o(pick),
    .free_cnt_o(free_cnt)
  );

  // ROB slots use nr (== slot number for a valid prefix); LSQ/RS/colour chain in slot order
  always_comb begin
    nr = 0;
    nl = 0;
    ns = 0;
    slot = '0;
    color_d = color_q;
    tag_d = {DISPATCH_WIDTH{TW'(TAG_NONE)}};
    lidx_d = '0;
    ridx_d = '0;
    rsv_d = '0;
    col_d = '0;
    set_mask = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      slot[k] = '{valid: in_valid[k], uses_rs: in_uses_rs[k], uses_lsq: in_uses_lsq[k], is_store: in_is_store[k]};
      if (slot[k].valid) begin
        tag_d[k*TW +: TW] = TW'((int'(rob_tail_q) + nr) % ROB_DEPTH + 1);
        if (slot[k].uses_lsq) begin
          lidx_d[k*LIW +: LIW] = LIW'((int'(lsq_tail_q) + nl) % LSQ_DEPTH);
          color_d = slot[k].is_store ? color_d + 1'b1 : color_d;
          col_d[k*COLOR_W +: COLOR_W] = color_d;
          nl++;
        end
        if (slot[k].uses_rs) begin
          ridx_d[k*SW +: SW] = pick[ns];
          rsv_d[k] = 1'b1;
          set_mask[pick[ns]] = 1'b1;
          ns++;
        end
        nr++;
      end
    end
    fit = (int'(rob_count_q) + nr <= ROB_DEPTH) && (int'(lsq_count_q) + nl <= LSQ_DEPTH) && (int'(free_cnt) >= ns);
    accept = fit && nr != 0 && !flush && (!out_valid_q || out_ready);
    rob_tail_d = flush ? rob_head : accept ? RIW'((int'(rob_tail_q) + nr) % ROB_DEPTH) : rob_tail_q;
    lsq_tail_d = flush ? lsq_head : accept ? LIW'((int'(lsq_tail_q) + nl) % LSQ_DEPTH) : lsq_tail_q;
    rob_count_d = flush ? '0 : rob_count_q + (accept ? TW'(nr) : '0) - TW'(rob_retire_cnt);
    lsq_count_d = flush ? '0 : lsq_count_q + (accept ? LCW'(nl) : '0) - LCW'(lsq_retire_cnt);
    busy_d = busy_q | (accept ? set_mask : '0);
    for (int p = 0; p < NUM_RS_FREE; p++)
      if (rs_free_valid[p]) busy_d[rs_free_idx[p*SW +: SW]] = 1'b0;
    busy_d = flush ? '0 : busy_d;
    out_valid_d = !flush && (accept || (out_valid_q && !out_ready));
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rob_tail_q <= '0;
      lsq_tail_q <= '0;
      rob_count_q <= '0;
      lsq_count_q <= '0;
      busy_q <= '0;
      color_q <= '0;
      out_valid_q <= 1'b0;
      slotv_q <= '0;
      tag_q <= '0;
      lidx_q <= '0;
      ridx_q <= '0;
      rsv_q <= '0;
      col_q <= '0;
    end else begin
      rob_tail_q <= rob_tail_d;
      lsq_tail_q <= lsq_tail_d;
      rob_count_q <= rob_count_d;
      lsq_count_q <= lsq_count_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        color_q <= color_d;
        slotv_q <= in_valid;
        tag_q <= tag_d;
        lidx_q <= lidx_d;
        ridx_q <= ridx_d;
        rsv_q <= rsv_d;
        col_q <= col_d;
      end
    end

  assign in_ready = accept;
  assign out_valid = out_valid_q;
  assign out_slot_valid = slotv_q;
  assign out_rob_tag = tag_q;
  assign out_lsq_idx = lidx_q;
  assign out_rs_idx = ridx_q;
  assign out_rs_valid = rsv_q;
  assign out_color = col_q;
  assign rob_count = rob_count_q;
  assign lsq_count = lsq_count_q;
  assign rob_full = rob_count_q == TW'(ROB_DEPTH);
  assign lsq_full = lsq_count_q == LCW'(LSQ_DEPTH);
endmodule

// File: tb/tb_dispatch_allocator.sv
// tb_dispatch_allocator: directed vectors checked against a queue-based allocation model.
module tb_dispatch_allocator;
  import dispatch_allocator_pkg::*;
  logic clk, reset, in_ready, flush, out_valid, out_ready, rob_full, lsq_full;
  logic [1:0] in_valid, in_uses_rs, in_uses_lsq, in_is_store, rob_retire_cnt, lsq_retire_cnt;
  logic [1:0] rs_free_valid, out_slot_valid, out_rs_valid;
  logic [5:0] rs_free_idx, out_lsq_idx, out_rs_idx;
  logic [3:0] rob_head, lsq_count;
  logic [2:0] lsq_head;
  logic [9:0] out_rob_tag;
  logic [7:0] out_color;
  logic [4:0] rob_count;
  int checks = 0, failures = 0;
  int m_rt, m_rc, m_lt, m_lc, m_nr, m_nl;
  bit [7:0] m_busy;
  bit [3:0] m_col;
  bit m_ov, m_acc;
  bit [1:0] m_sv;
  alloc_result_t m_res [2];
  int freeq [$];

  dispatch_allocator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_uses_rs(in_uses_rs),
    .in_uses_lsq(in_uses_lsq), .in_is_store(in_is_store), .in_ready(in_ready),
    .rob_retire_cnt(rob_retire_cnt), .lsq_retire_cnt(lsq_retire_cnt),
    .rs_free_valid(rs_free_valid), .rs_free_idx(rs_free_idx), .flush(flush),
    .rob_head(rob_head), .lsq_head(lsq_head), .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_valid(out_slot_valid), .out_rob_tag(out_rob_tag), .out_lsq_idx(out_lsq_idx),
    .out_rs_idx(out_rs_idx), .out_rs_valid(out_rs_valid), .out_color(out_color),
    .rob_count(rob_count), .lsq_count(lsq_count), .rob_full(rob_full), .lsq_full(lsq_full)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic grp(input logic [1:0] v, input logic [1:0] r, input logic [1:0] l, input logic [1:0] s);
    in_valid = v;
    in_uses_rs = r;
    in_uses_lsq = l;
    in_is_store = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_ready();
    int nr, nl, ns, fr;
    nr = 0; nl = 0; ns = 0; fr = 0;
    for (int k = 0; k < 2; k++)
      if (in_valid[k]) begin
        nr++;
        nl += int'(in_uses_lsq[k]);
        ns += int'(in_uses_rs[k]);
      end
    for (int i = 0; i < 8; i++) fr += int'(!m_busy[i]);
    return nr > 0 && m_rc + nr <= 16 && m_lc + nl <= 8 && fr >= ns && !flush && (!m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rt = 0; m_rc = 0; m_lt = 0; m_lc = 0; m_busy = 0; m_col = 0; m_ov = 0; m_sv = 0;
      m_res[0] = '0;
      m_res[1] = '0;
    end else begin
      m_acc = m_ready();
      m_nr = 0;
      m_nl = 0;
      if (m_acc) begin
        freeq.delete();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) freeq.push_back(i);
        for (int k = 0; k < 2; k++) begin
          m_res[k] = '0;
          if (in_valid[k]) begin
            m_res[k].rob_tag = 5'((m_rt + m_nr) % 16 + 1);
            m_nr++;
            if (in_uses_lsq[k]) begin
              m_res[k].lsq_idx = 3'((m_lt + m_nl) % 8);
              m_nl++;
              if (in_is_store[k]) m_col = m_col + 1;
              m_res[k].color = m_col;
            end
            if (in_uses_rs[k]) begin
              m_res[k].rs_idx = 3'(freeq.pop_front());
              m_res[k].rs_valid = 1;
              m_busy[m_res[k].rs_idx] = 1;
            end
          end
        end
        m_sv = in_valid;
        m_ov = 1;
      end else if (out_ready) m_ov = 0;
      for (int p = 0; p < 2; p++) if (rs_free_valid[p]) m_busy[rs_free_idx[p*3 +: 3]] = 0;
      m_rc = m_rc + m_nr - int'(rob_retire_cnt);
      m_lc = m_lc + m_nl - int'(lsq_retire_cnt);
      m_rt = (m_rt + m_nr) % 16;
      m_lt = (m_lt + m_nl) % 8;
      if (flush) begin
        m_rt = int'(rob_head); m_lt = int'(lsq_head); m_rc = 0; m_lc = 0; m_busy = 0; m_ov = 0;
      end
    end
  end

  always @(negedge clk) if (reset) begin
    chk("in_ready", in_ready, int'(m_ready()));
    chk("out_valid", out_valid, int'(m_ov));
    chk("rob_count", rob_count, m_rc);
    chk("lsq_count", lsq_count, m_lc);
    chk("rob_full", rob_full, int'(m_rc == 16));
    chk("lsq_full", lsq_full, int'(m_lc == 8));
    if (m_ov) begin
      chk("slot_valid", out_slot_valid, m_sv);
      for (int k = 0; k < 2; k++) begin
        chk("rob_tag", out_rob_tag[k*5 +: 5], m_res[k].rob_tag);
        chk("lsq_idx", out_lsq_idx[k*3 +: 3], m_res[k].lsq_idx);
        chk("rs_idx", out_rs_idx[k*3 +: 3], m_res[k].rs_idx);
        chk("rs_valid", out_rs_valid[k], m_res[k].rs_valid);
        chk("color", out_color[k*4 +: 4], m_res[k].color);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 0; flush = 0; out_ready = 1; rob_head = 0; lsq_head = 0;
    rob_retire_cnt = 0; lsq_retire_cnt = 0; rs_free_valid = 0; rs_free_idx = 0;
    grp(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rob_count", rob_count, 0);
    chk("rst_tag0", out_rob_tag[4:0], 0);
    @(posedge clk);
    #1 reset = 1;
    grp(2'b11, 2'b11, 2'b00, 2'b00);
    @(negedge clk);
    chk("t1_ready", in_ready, 1);
    tick(); grp(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_tag0", out_rob_tag[4:0], 1);
    chk("t1_tag1", out_rob_tag[9:5], 2);
    chk("t1_rs0", out_rs_idx[2:0], 0);
    chk("t1_rs1", out_rs_idx[5:3], 1);
    chk("t1_rob_count", rob_count, 2);
    tick(); grp(2'b11, 2'b00, 2'b11, 2'b11);
    tick(); grp(2'b01, 2'b00, 2'b01, 2'b01);
    tick(); grp(0, 0, 0, 0);
    @(negedge clk);
    chk("setup_color", out_color[3:0], 3);
    chk("setup_lsq", out_lsq_idx[2:0], 2);
    tick(); flush = 1; rob_head = 0; lsq_head = 0; grp(2'b11, 2'b11, 2'b00, 2'b00);
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    tick(); flush = 0; grp(2'b11, 2'b00, 2'b11, 2'b01);
    @(negedge clk);
    chk("flush_rob_count", rob_count, 0);
    chk("flush_out_valid", out_valid, 0);
    tick(); grp(2'b01, 2'b00, 2'b01, 2'b01);
    @(negedge clk);
    chk("t2_color0", out_color[3:0], 4);
    chk("t2_color1", out_color[7:4], 4);
    chk("t2_lsq0", out_lsq_idx[2:0], 0);
    chk("t2_lsq1", out_lsq_idx[5:3], 1);
    chk("t2_lsq_count", lsq_count, 2);
    tick(); grp(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_next_store_color", out_color[3:0], 5);
    tick();
    repeat (6) begin grp(2'b11, 0, 0, 0); tick(); end
    rob_retire_cnt = 1; lsq_retire_cnt = 1;
    @(negedge clk);
    chk("t3_stall", in_ready, 0);
    chk("t3_rob_count", rob_count, 15);
    tick(); rob_retire_cnt = 0; lsq_retire_cnt = 0;
    @(negedge clk);
    chk("t3_rob_count_after", rob_count, 14);
    chk("t3_ready", in_ready, 1);
    tick(); grp(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_tag0", out_rob_tag[4:0], 16);
    chk("t4_tag1", out_rob_tag[9:5], 1);
    chk("t4_rob_full", rob_full, 1);
    tick(); flush = 1; rob_head = 0; lsq_head = 0;
    tick(); flush = 0;
    repeat (3) begin grp(2'b11, 2'b11, 0, 0); tick(); end
    grp(2'b01, 2'b01, 0, 0); tick();
    grp(2'b11, 2'b11, 0, 0); rs_free_valid = 2'b01; rs_free_idx = 6'd2;
    @(negedge clk);
    chk("t5_stall", in_ready, 0);
    tick(); rs_free_valid = 0;
    @(negedge clk);
    chk("t5_ready", in_ready, 1);
    tick(); grp(0, 0, 0, 0); out_ready = 0;
    @(negedge clk);
    chk("t5_rs0", out_rs_idx[2:0], 2);
    chk("t5_rs1", out_rs_idx[5:3], 7);
    chk("t5_rs_valid", out_rs_valid, 3);
    tick(); grp(2'b01, 2'b00, 2'b01, 2'b00);
    @(negedge clk);
    chk("t6_hold_valid", out_valid, 1);
    chk("t6_hold_rs0", out_rs_idx[2:0], 2);
    chk("t6_hold_ready", in_ready, 0);
    tick(); flush = 1; rob_head = 5; lsq_head = 6;
    @(negedge clk);
    chk("t6_flush_ready", in_ready, 0);
    tick(); flush = 0; out_ready = 1;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_rob_count", rob_count, 0);
    chk("t6_lsq_count", lsq_count, 0);
    tick(); grp(0, 0, 0, 0);
    @(negedge clk);
    chk("t6_tag", out_rob_tag[4:0], 6);
    chk("t6_color", out_color[3:0], 5);
    chk("t6_lsq", out_lsq_idx[2:0], 6);
    tick(); grp(2'b11, 2'b11, 0, 0);
    tick(); grp(0, 0, 0, 0);
    #2 reset = 0;
    #1;
    chk("async_rob_count", rob_count, 0);
    chk("async_out_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
